// File: rtl/trace_change_sched_pkg.sv
// Shared types and width helpers for the trace change scheduler.
package trace_sched_pkg;

    // Pass sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SCAN,
        EMIT,
        DONE
    } state_e;

    // Generic record layout for consumers that want one packed word per record.
    localparam int REC_IDX_W = 16;

    typedef struct packed {
        logic [REC_IDX_W-1:0] inst;
        logic [REC_IDX_W-1:0] var_idx;
        logic                 value;
    } rec_t;

    // Index width for a range of n values; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trace_change_sched_if.sv
// Serial change-record bus between the scheduler and the trace-record consumer.
interface trace_change_sched_if #(
    parameter int IW = 4,
    parameter int VW = 4
);
    logic          rec_valid;
    logic          rec_ready;
    logic [IW-1:0] rec_inst;
    logic [VW-1:0] rec_var;
    logic          rec_value;

    modport master (
        output rec_valid,
        output rec_inst,
        output rec_var,
        output rec_value,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_inst,
        input  rec_var,
        input  rec_value,
        output rec_ready
    );
endinterface

// File: rtl/trace_change_sched_shadow_bank.sv
// Last-dumped value of every traced var, plus a flag saying the copy is complete.
module trace_shadow_bank #(
    parameter int NBITS = 100,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_i,
    output logic          rd_bit_o,
    input  logic          wr_en_i,
    input  logic          wr_bit_i,
    input  logic          set_valid_i,
    input  logic          clear_valid_i,
    output logic          valid_o
);
    logic [NBITS-1:0] bits_q;
    logic             valid_q;

    // Shadow bits only matter once valid_q is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            bits_q[addr_i] <= wr_bit_i;
        end
    end

    // Validity flag: cleared when a pass starts or on reset, set when a pass completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (clear_valid_i) begin
            valid_q <= 1'b0;
        end else if (set_valid_i) begin
            valid_q <= 1'b1;
        end
    end

    assign rd_bit_o = bits_q[addr_i];
    assign valid_o  = valid_q;

endmodule

// File: rtl/trace_change_sched.sv
// Snapshot a bank of one-bit trace vars and emit a record for each var that changed.
module trace_change_sched
    import trace_sched_pkg::*;
#(
    parameter int INSTANCES = 10,
    parameter int VARS      = 10,
    parameter int IW        = idx_w(INSTANCES),
    parameter int VW        = idx_w(VARS),
    parameter int CW        = idx_w(INSTANCES*VARS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INSTANCES*VARS-1:0]  sample_i,
    input  logic                       snap_req,
    input  logic                       full_dump,
    output logic                       busy,
    output logic                       done,
    output logic [CW-1:0]              rec_count,
    trace_change_sched_if.master       rec
);
    localparam int NBITS = INSTANCES * VARS;
    localparam int AW    = idx_w(NBITS);

    state_e         state_q, state_d;
    logic           force_q, force_d;
    logic [NBITS-1:0] snap_q;
    logic           snap_load;
    logic [IW-1:0]  cur_inst_q, cur_inst_d;
    logic [VW-1:0]  cur_var_q, cur_var_d;
    logic           rec_valid_q, rec_valid_d;
    logic [IW-1:0]  rec_inst_q, rec_inst_d;
    logic [VW-1:0]  rec_var_q, rec_var_d;
    logic           rec_value_q, rec_value_d;
    logic [CW-1:0]  count_q, count_d;

    logic [AW-1:0]  addr;
    logic           snap_bit;
    logic           shadow_bit;
    logic           shadow_valid;
    logic           sh_wr_en;
    logic           sh_set;
    logic           sh_clr;

    logic           adv_end;
    logic [IW-1:0]  adv_inst;
    logic [VW-1:0]  adv_var;

    // Flat bit position of the cursor; the same address serves snapshot and shadow.
    assign addr     = AW'(int'(cur_inst_q) * VARS + int'(cur_var_q));
    assign snap_bit = snap_q[addr];

    trace_shadow_bank #(
        .NBITS (NBITS),
        .AW    (AW)
    ) u_shadow (
        .clk           (clk),
        .rst           (rst),
        .addr_i        (addr),
        .rd_bit_o      (shadow_bit),
        .wr_en_i       (sh_wr_en),
        .wr_bit_i      (rec_value_q),
        .set_valid_i   (sh_set),
        .clear_valid_i (sh_clr),
        .valid_o       (shadow_valid)
    );

    // Cursor successor: var-minor, wrapping into the next instance; adv_end marks the last var.
    always_comb begin
        adv_end  = (cur_var_q == VW'(VARS - 1)) && (cur_inst_q == IW'(INSTANCES - 1));
        adv_var  = cur_var_q + VW'(1);
        adv_inst = cur_inst_q;
        if (cur_var_q == VW'(VARS - 1)) begin
            adv_var  = '0;
            adv_inst = cur_inst_q + IW'(1);
        end
    end

    // Pass sequencing: next state, cursor, record and shadow controls.
    always_comb begin
        state_d     = state_q;
        force_d     = force_q;
        cur_inst_d  = cur_inst_q;
        cur_var_d   = cur_var_q;
        rec_valid_d = rec_valid_q;
        rec_inst_d  = rec_inst_q;
        rec_var_d   = rec_var_q;
        rec_value_d = rec_value_q;
        count_d     = count_q;
        snap_load   = 1'b0;
        sh_wr_en    = 1'b0;
        sh_set      = 1'b0;
        sh_clr      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (snap_req) begin
                    state_d = SNAP;
                    force_d = full_dump | ~shadow_valid;
                    count_d = '0;
                    sh_clr  = 1'b1;
                end
            end
            SNAP: begin
                snap_load  = 1'b1;
                cur_inst_d = '0;
                cur_var_d  = '0;
                state_d    = SCAN;
            end
            SCAN: begin
                if (force_q || (snap_bit != shadow_bit)) begin
                    rec_valid_d = 1'b1;
                    rec_inst_d  = cur_inst_q;
                    rec_var_d   = cur_var_q;
                    rec_value_d = snap_bit;
                    state_d     = EMIT;
                end else begin
                    cur_inst_d = adv_inst;
                    cur_var_d  = adv_var;
                    state_d    = adv_end ? DONE : SCAN;
                end
            end
            EMIT: begin
                // The record stays untouched until the consumer takes it.
                if (rec.rec_ready) begin
                    rec_valid_d = 1'b0;
                    sh_wr_en    = 1'b1;
                    count_d     = count_q + CW'(1);
                    cur_inst_d  = adv_inst;
                    cur_var_d   = adv_var;
                    state_d     = adv_end ? DONE : SCAN;
                end
            end
            DONE: begin
                sh_set  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any pass in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            force_q     <= 1'b0;
            cur_inst_q  <= '0;
            cur_var_q   <= '0;
            rec_valid_q <= 1'b0;
            rec_inst_q  <= '0;
            rec_var_q   <= '0;
            rec_value_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            force_q     <= force_d;
            cur_inst_q  <= cur_inst_d;
            cur_var_q   <= cur_var_d;
            rec_valid_q <= rec_valid_d;
            rec_inst_q  <= rec_inst_d;
            rec_var_q   <= rec_var_d;
            rec_value_q <= rec_value_d;
            count_q     <= count_d;
        end
    end

    // Snapshot of the live bank, frozen for the rest of the pass.
    always_ff @(posedge clk) begin
        if (snap_load) begin
            snap_q <= sample_i;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign rec_count     = count_q;
    assign rec.rec_valid = rec_valid_q;
    assign rec.rec_inst  = rec_inst_q;
    assign rec.rec_var   = rec_var_q;
    assign rec.rec_value = rec_value_q;

endmodule
